dense_layer: RTL

DENSE_LAYER -- requirements
Module: dense_layer

---
 rtl/dense_layer.sv | 99 +++++++++
 1 files changed

// File: rtl/dense_layer.sv
// dense_layer: fully connected layer, one MAC per cycle over IN_SIZE features for each of OUT_SIZE neurons.
// Define DENSE_RELU_EN to clamp negative results to zero before they are written.
module dense_layer #(
  parameter int IN_SIZE   = 1764,
  parameter int OUT_SIZE  = 10,
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [BIT_WIDTH-1:0]                data_rd,
  output logic [$clog2(IN_SIZE)-1:0]          addr_rd,
  input  logic [BIT_WIDTH-1:0]                weight_rd,
  output logic [$clog2(IN_SIZE*OUT_SIZE)-1:0] weight_addr,
  input  logic [BIT_WIDTH-1:0]                bias_rd,
  output logic [$clog2(OUT_SIZE)-1:0]         bias_addr,
  output logic [BIT_WIDTH-1:0]                data_wr,
  output logic [$clog2(OUT_SIZE)-1:0]         addr_wr,
  output logic                                wren,
  output logic                                busy,
  output logic                                done
);
  localparam int AW = $clog2(IN_SIZE);
  localparam int WW = $clog2(IN_SIZE*OUT_SIZE);
  localparam int NW = $clog2(OUT_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(IN_SIZE-1);
  localparam logic [NW-1:0] LAST_NEURON = NW'(OUT_SIZE-1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((2**(BIT_WIDTH-1))-1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - ACC_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;
  state_t state;
  logic [AW-1:0] idx;
  logic [NW-1:0] neuron;
  logic vld;
  logic signed [ACC_WIDTH-1:0] acc, sum, shr;
  logic signed [2*BIT_WIDTH-1:0] prod;
  logic signed [BIT_WIDTH-1:0] bias_q, sat, res;
  always_comb begin
    prod = $signed(data_rd) * $signed(weight_rd);
    sum = acc + (ACC_WIDTH'(bias_q) <<< FRAC_BITS);
    shr = sum >>> FRAC_BITS;
    sat = shr > MAXV ? MAXV[BIT_WIDTH-1:0] : shr < MINV ? MINV[BIT_WIDTH-1:0] : shr[BIT_WIDTH-1:0];
  end
`ifdef DENSE_RELU_EN
  assign res = sat[BIT_WIDTH-1] ? '0 : sat;
`else
  assign res = sat;
`endif
  assign addr_rd = idx;
  assign weight_addr = WW'(neuron) * WW'(IN_SIZE) + WW'(idx);
  assign bias_addr = neuron;
  assign wren = state == WRITE;
  assign data_wr = wren ? res : '0;
  assign addr_wr = wren ? neuron : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // vld marks the cycle in which the product of the previously issued address is on the read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      neuron <= '0;
      vld <= 1'b0;
      acc <= '0;
      bias_q <= '0;
    end else begin
      vld <= state == MAC;
      if (vld) acc <= acc + ACC_WIDTH'(prod);
      case (state)
        IDLE: if (start) begin
          state <= MAC;
          idx <= '0;
          neuron <= '0;
          acc <= '0;
        end
        MAC: begin
          idx <= idx == LAST_IDX ? '0 : idx + 1'b1;
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          bias_q <= bias_rd;
          state <= WRITE;
        end
        WRITE: if (neuron == LAST_NEURON) begin
          state <= DONE;
          neuron <= '0;
        end else begin
          state <= MAC;
          neuron <= neuron + 1'b1;
          acc <= '0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
